// File: rtl/reaction_pkg.sv
// rtl/reaction_pkg.sv - shared state encoding and default counter width
package reaction_pkg;

    localparam int DEFAULT_WIDTH = 16;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        MEASURE  = 2'd1,
        DONE     = 2'd2,
        WAIT_LOW = 2'd3
    } state_e;

endpackage

// File: rtl/edge_detect.sv
// rtl/edge_detect.sv - rising-edge detector for an already synchronised level
module edge_detect (
    input  logic clk,
    input  logic rst,
    input  logic in,
    output logic rise
);

    logic in_q;
    logic in_d;

    always_comb begin
        in_d = in;
    end

    // Cleared in reset so a level already high at release counts as an edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            in_q <= 1'b0;
        end else begin
            in_q <= in_d;
        end
    end

    assign rise = in & ~in_q;

endmodule

// File: rtl/reaction_timer.sv
// rtl/reaction_timer.sv - counts clk cycles from a start pulse to the next button press
module reaction_timer
    import reaction_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             press,
    output logic [WIDTH-1:0] reaction,
    output logic             valid,
    output logic             overflow,
    output logic             early,
    output logic             busy
);

    localparam logic [WIDTH-1:0] COUNT_MAX = '1;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] count_q, count_d;
    logic [WIDTH-1:0] reaction_q, reaction_d;
    logic             overflow_q, overflow_d;
    logic             early_q, early_d;
    logic             press_rise;

    edge_detect u_press_edge (
        .clk  (clk),
        .rst  (rst),
        .in   (press),
        .rise (press_rise)
    );

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:     if (start) state_d = MEASURE;
            MEASURE:  if (press_rise || (count_q == COUNT_MAX)) state_d = DONE;
            DONE:     state_d = press ? WAIT_LOW : IDLE;
            WAIT_LOW: if (!press) state_d = IDLE;
            default:  state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // A press edge coinciding with start is swallowed: no early pulse, no result.
    always_comb begin
        count_d    = count_q;
        reaction_d = reaction_q;
        overflow_d = overflow_q;
        early_d    = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    count_d = '0;
                end else if (press_rise) begin
                    early_d = 1'b1;
                end
            end
            MEASURE: begin
                if (press_rise) begin
                    reaction_d = count_q;
                    overflow_d = 1'b0;
                end else if (count_q == COUNT_MAX) begin
                    reaction_d = COUNT_MAX;
                    overflow_d = 1'b1;
                end else begin
                    count_d = count_q + 1'b1;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q    <= '0;
            reaction_q <= '0;
            overflow_q <= 1'b0;
            early_q    <= 1'b0;
        end else begin
            count_q    <= count_d;
            reaction_q <= reaction_d;
            overflow_q <= overflow_d;
            early_q    <= early_d;
        end
    end

    assign reaction = reaction_q;
    assign overflow = overflow_q;
    assign early    = early_q;
    assign valid    = (state_q == DONE);
    assign busy     = (state_q == MEASURE);

endmodule
